// File: rtl/instr_writer.sv
// Instruction entry writer: two debounced buttons step through op1/op2/cmd fields
// taken from the switches and push each assembled 32-bit word to instruction memory.
module instr_writer #(
  parameter int DEPTH     = 100,
  parameter int ADDR_W    = 7,
  parameter int DB_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       sw,
  input  logic              btn_next,
  input  logic              btn_clr,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W-1:0] count,
  output logic              full,
  output logic [1:0]        field
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

  localparam logic [2:0] S_OP1   = 3'd0;
  localparam logic [2:0] S_OP2   = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FULL  = 3'd4;

  // Button index 0 = next, 1 = clr.
  logic [1:0]       w_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_db;
  logic [1:0]       r_press;
  logic [CNT_W-1:0] r_cnt [2];

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [11:0]       r_op1;
  logic [11:0]       w_op1_nxt;
  logic [11:0]       r_op2;
  logic [11:0]       w_op2_nxt;
  logic [3:0]        r_cmd;
  logic [3:0]        w_cmd_nxt;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_count_nxt;
  logic [ADDR_W:0]   w_count_inc;
  logic              w_next;
  logic              w_clr;

  assign w_raw = {btn_clr, btn_next};

  // Level flips only after DB_CYCLES consecutive disagreeing samples; press is the rising flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_press <= '0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == DB_LAST) begin
            r_db[i]    <= r_sync2[i];
            r_press[i] <= r_sync2[i];
            r_cnt[i]   <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_next      = r_press[0];
  assign w_clr       = r_press[1];
  assign w_count_inc = {1'b0, r_count} + (ADDR_W + 1)'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_op1_nxt   = r_op1;
    w_op2_nxt   = r_op2;
    w_cmd_nxt   = r_cmd;
    w_count_nxt = r_count;
    case (r_state)
      S_OP1: begin
        if (!w_clr && w_next) begin
          w_op1_nxt   = sw;
          w_state_nxt = S_OP2;
        end
      end
      S_OP2, S_CMD: begin
        if (w_clr) begin
          w_op1_nxt   = '0;
          w_op2_nxt   = '0;
          w_cmd_nxt   = '0;
          w_state_nxt = S_OP1;
        end else if (w_next && (r_state == S_OP2)) begin
          w_op2_nxt   = sw;
          w_state_nxt = S_CMD;
        end else if (w_next) begin
          w_cmd_nxt   = sw[3:0];
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          w_count_nxt = w_count_inc[ADDR_W-1:0];
          w_state_nxt = (w_count_inc == DEPTH_X) ? S_FULL : S_OP1;
        end
      end
      S_FULL: begin
        if (w_clr) begin
          w_count_nxt = '0;
          w_state_nxt = S_OP1;
        end
      end
      default: w_state_nxt = S_OP1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OP1;
      r_op1   <= '0;
      r_op2   <= '0;
      r_cmd   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op1   <= w_op1_nxt;
      r_op2   <= w_op2_nxt;
      r_cmd   <= w_cmd_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign wr_valid = (r_state == S_WRITE);
  assign wr_data  = {r_op1, r_op2, r_cmd, 4'h0};
  assign count    = r_count;
  assign full     = (r_state == S_FULL);
  // Once full, count equals DEPTH; keep the address inside the memory.
  assign wr_addr  = full ? ADDR_TOP : r_count;

  always_comb begin
    case (r_state)
      S_OP1:   field = 2'd0;
      S_OP2:   field = 2'd1;
      S_CMD:   field = 2'd2;
      default: field = 2'd3;
    endcase
  end

endmodule
